// File: rtl/phoenix_loader_pkg.sv
// Shared constants for the phoeniX boot-time program loader.
// Optional checksum support is enabled with PHOENIX_LOADER_CHECKSUM_EN.
package phoenix_loader_pkg;

   localparam logic [2:0] ST_INIT     = 3'd0;
   localparam logic [2:0] ST_COUNT_LO = 3'd1;
   localparam logic [2:0] ST_COUNT_HI = 3'd2;
   localparam logic [2:0] ST_DATA     = 3'd3;
   localparam logic [2:0] ST_WRITE    = 3'd4;
   localparam logic [2:0] ST_CHECK    = 3'd5;
   localparam logic [2:0] ST_DONE     = 3'd6;
   localparam logic [2:0] ST_ERROR    = 3'd7;

   localparam int BYTES_PER_WORD = 4;
   localparam int COUNT_WIDTH    = 16;

   function automatic logic state_accepts_byte(input logic [2:0] st);
      logic acc;
      case (st)
         ST_COUNT_LO,
         ST_COUNT_HI,
         ST_DATA:  acc = 1'b1;
`ifdef PHOENIX_LOADER_CHECKSUM_EN
         ST_CHECK: acc = 1'b1;
`endif
         default:  acc = 1'b0;
      endcase
      return acc;
   endfunction

endpackage

// File: rtl/phoenix_program_loader_word_assembler.sv
// Byte counter plus little-endian shift register that packs four
// accepted bytes into one 32-bit word.
module loader_word_assembler
   import phoenix_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_complete_o,
   output logic [31:0] word_o
);

   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] word_q, word_d;

   // New bytes enter at the top so the first byte ends up in bits [7:0].
   always_comb begin
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      if (byte_valid_i) begin
         byte_cnt_d = byte_cnt_q + 2'd1;
         word_d     = {byte_i, word_q[31:8]};
      end else begin
         byte_cnt_d = byte_cnt_q;
         word_d     = word_q;
      end
   end

   // Assembler state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         byte_cnt_q <= 2'd0;
         word_q     <= 32'd0;
      end else begin
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
      end
   end

   assign word_complete_o = byte_valid_i && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
   assign word_o          = word_q;

endmodule

// File: rtl/phoenix_program_loader.sv
// Boot-time program loader: byte stream -> instruction memory words, holds
// the core in reset until loaded. Trailing checksum byte: PHOENIX_LOADER_CHECKSUM_EN.
module phoenix_program_loader
   import phoenix_loader_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 12,
   parameter int BASE_ADDRESS  = 0
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   output logic                     rx_ready,
   output logic                     mem_write_enable,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [31:0]              mem_write_data,
   output logic                     core_reset,
   output logic                     load_done,
   output logic                     load_error
);

   localparam logic [31:0] MAX_WORDS = 32'((1 << (ADDRESS_WIDTH - 2)) - (BASE_ADDRESS / 4));
   localparam logic [ADDRESS_WIDTH-1:0] BASE_ADDR = ADDRESS_WIDTH'(BASE_ADDRESS);
`ifdef PHOENIX_LOADER_CHECKSUM_EN
   localparam logic [2:0] ST_FINISH = ST_CHECK;
`else
   localparam logic [2:0] ST_FINISH = ST_DONE;
`endif

   logic [2:0]               state_q, state_d;
   logic [7:0]               count_lo_q, count_lo_d;
   logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                     we_q, we_d;
   logic                     core_reset_q, core_reset_d;
   logic                     done_q, done_d;
   logic                     error_q, error_d;
`ifdef PHOENIX_LOADER_CHECKSUM_EN
   logic [7:0]               sum_q, sum_d;
`endif

   logic                     xfer_s;
   logic                     data_xfer_s;
   logic                     word_complete_s;
   logic [31:0]              word_s;
   logic [COUNT_WIDTH-1:0]   count_s;

   assign rx_ready    = state_accepts_byte(state_q);
   assign xfer_s      = rx_valid && rx_ready;
   assign data_xfer_s = xfer_s && (state_q == ST_DATA);
   assign count_s     = {rx_data, count_lo_q};

   loader_word_assembler u_assembler (
      .clk_i           (CLK),
      .rst_i           (reset),
      .byte_valid_i    (data_xfer_s),
      .byte_i          (rx_data),
      .word_complete_o (word_complete_s),
      .word_o          (word_s)
   );

   // Load sequencing; status outputs are derived from the next state so they register with it.
   always_comb begin
      state_d     = state_q;
      count_lo_d  = count_lo_q;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      we_d        = 1'b0;
      case (state_q)
         ST_INIT: state_d = ST_COUNT_LO;
         ST_COUNT_LO: begin
            if (xfer_s) begin
               count_lo_d = rx_data;
               state_d    = ST_COUNT_HI;
            end else begin
               state_d    = ST_COUNT_LO;
            end
         end
         ST_COUNT_HI: begin
            if (!xfer_s) begin
               state_d = ST_COUNT_HI;
            end else if (count_s == 16'd0) begin
               state_d = ST_FINISH;
            end else if ({16'd0, count_s} > MAX_WORDS) begin
               state_d = ST_ERROR;
            end else begin
               remaining_d = count_s;
               state_d     = ST_DATA;
            end
         end
         ST_DATA: begin
            if (word_complete_s) begin
               state_d = ST_WRITE;
               we_d    = 1'b1;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_WRITE: begin
            addr_d      = addr_q + ADDRESS_WIDTH'(BYTES_PER_WORD);
            remaining_d = remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
               state_d = ST_FINISH;
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef PHOENIX_LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (!xfer_s) begin
               state_d = ST_CHECK;
            end else if (rx_data == sum_q) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_ERROR;
            end
         end
`endif
         ST_DONE:  state_d = ST_DONE;
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_ERROR;
      endcase
      done_d       = (state_d == ST_DONE);
      error_d      = (state_d == ST_ERROR);
      core_reset_d = (state_d != ST_DONE);
   end

`ifdef PHOENIX_LOADER_CHECKSUM_EN
   // Running payload checksum; the count header is not included.
   always_comb begin
      if (data_xfer_s) begin
         sum_d = sum_q + rx_data;
      end else begin
         sum_d = sum_q;
      end
   end

   // Checksum register.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         sum_q <= 8'd0;
      end else begin
         sum_q <= sum_d;
      end
   end
`endif

   // Loader state and output registers.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q      <= ST_INIT;
         count_lo_q   <= 8'd0;
         remaining_q  <= 16'd0;
         addr_q       <= BASE_ADDR;
         we_q         <= 1'b0;
         core_reset_q <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_lo_q   <= count_lo_d;
         remaining_q  <= remaining_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         core_reset_q <= core_reset_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign mem_write_enable = we_q;
   assign mem_address      = addr_q;
   assign mem_write_data   = word_s;
   assign core_reset       = core_reset_q;
   assign load_done        = done_q;
   assign load_error       = error_q;

endmodule

// File: tb/tb_phoenix_program_loader.sv
// Table-driven, scoreboarded bench for phoenix_program_loader (either checksum build).
module tb_phoenix_program_loader;

   logic        CLK;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        mem_write_enable;
   logic [11:0] mem_address;
   logic [31:0] mem_write_data;
   logic        core_reset;
   logic        load_done;
   logic        load_error;

   phoenix_program_loader #(.ADDRESS_WIDTH(12), .BASE_ADDRESS(0)) dut (
      .CLK              (CLK),
      .reset            (reset),
      .rx_valid         (rx_valid),
      .rx_data          (rx_data),
      .rx_ready         (rx_ready),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .core_reset       (core_reset),
      .load_done        (load_done),
      .load_error       (load_error)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

`ifdef PHOENIX_LOADER_CHECKSUM_EN
   localparam int         XB        = 1;
   localparam logic [7:0] SUM_BASIC = 8'h3b;
   localparam logic [7:0] SUM_DB    = 8'h38;
   localparam logic [7:0] SUM_ZERO  = 8'h00;
`else
   localparam int         XB        = 0;
   localparam logic [7:0] SUM_BASIC = 8'h00;
   localparam logic [7:0] SUM_DB    = 8'h00;
   localparam logic [7:0] SUM_ZERO  = 8'h00;
`endif

   typedef struct {
      logic [10:0][7:0] b;
      int               len;
      bit               gaps;
      bit               exp_done;
      bit               exp_err;
      int               nw;
      logic [1:0][31:0] w;
   } vec_t;

   typedef struct packed {
      logic [11:0] addr;
      logic [31:0] data;
   } wr_t;

   vec_t vecs [6];
   wr_t  exp_q [$];
   int   checks;
   int   errors;
   int   writes_seen;
   logic prev_we;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Write monitor: pops the scoreboard on every strobe.
   always @(negedge CLK) begin
      if (mem_write_enable === 1'b1) begin
         wr_t e;
         writes_seen++;
         check("strobe_width", {31'd0, prev_we}, 32'd0);
         check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", {20'd0, mem_address}, 32'hffffffff);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", {20'd0, mem_address}, {20'd0, e.addr});
            check("write_data", mem_write_data, e.data);
         end
      end
      if (load_done === 1'b1 && load_error === 1'b1)
         check("done_err_exclusive", {31'd0, load_error}, 32'd0);
      prev_we = mem_write_enable;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      waited = 0;
      for (int g = 0; g < gap; g++) begin
         @(negedge CLK);
         rx_valid = 1'b0;
      end
      @(negedge CLK);
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && waited < 50) begin
         @(negedge CLK);
         waited++;
      end
      if (!rx_ready) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      @(posedge CLK);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge CLK);
      #2 reset = 1'b1;
      #1;
      check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("rst_we", {31'd0, mem_write_enable}, 32'd0);
      check("rst_addr", {20'd0, mem_address}, 32'd0);
      check("rst_wdata", mem_write_data, 32'd0);
      check("rst_core_reset", {31'd0, core_reset}, 32'd1);
      check("rst_flags", {30'd0, load_done, load_error}, 32'd0);
      @(negedge CLK);
      reset       = 1'b0;
      writes_seen = 0;
      exp_q.delete();
   endtask

   task automatic wait_terminal();
      int cnt;
      cnt = 0;
      while (!(load_done || load_error) && cnt < 30) begin
         @(negedge CLK);
         cnt++;
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t v;
      int   gap;
      v = vecs[idx];
      apply_reset();
      for (int i = 0; i < v.len; i++) begin
         gap = v.gaps ? int'($urandom_range(0, 7)) : 0;
         if (i >= 2 && ((i - 2) % 4) == 3 && ((i - 2) / 4) < v.nw)
            exp_q.push_back('{addr: 12'(4 * ((i - 2) / 4)), data: v.w[(i - 2) / 4]});
         send_byte(v.b[i], gap);
      end
      wait_terminal();
      @(negedge CLK);
      check("load_done", {31'd0, load_done}, {31'd0, v.exp_done});
      check("load_error", {31'd0, load_error}, {31'd0, v.exp_err});
      check("core_reset", {31'd0, core_reset}, {31'd0, !v.exp_done});
      check("write_count", writes_seen, v.nw);
      check("scoreboard_empty", exp_q.size(), 32'd0);
      check("rx_ready_terminal", {31'd0, rx_ready}, 32'd0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      writes_seen = 0;
      prev_we  = 1'b0;
      reset    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;

      vecs[0] = '{b: {SUM_BASIC, 8'h00, 8'h10, 8'h00, 8'h73, 8'h00, 8'ha0, 8'h05, 8'h13, 8'h00, 8'h02},
                  len: 10 + XB, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, nw: 2,
                  w: {32'h00100073, 32'h00a00513}};
      vecs[1] = vecs[0];
      vecs[1].gaps = 1'b1;
      vecs[2] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, SUM_ZERO, 8'h00, 8'h00},
                  len: 2 + XB, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, nw: 0,
                  w: {32'h0, 32'h0}};
      vecs[3] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h01},
                  len: 2, gaps: 1'b0, exp_done: 1'b0, exp_err: 1'b1, nw: 0,
                  w: {32'h0, 32'h0}};
      vecs[4] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, SUM_DB, 8'hde, 8'had, 8'hbe, 8'hef, 8'h00, 8'h01},
                  len: 6 + XB, gaps: 1'b1, exp_done: 1'b1, exp_err: 1'b0, nw: 1,
                  w: {32'h0, 32'hdeadbeef}};
`ifdef PHOENIX_LOADER_CHECKSUM_EN
      vecs[5] = vecs[0];
      vecs[5].b[10] = 8'h3c;
      vecs[5].exp_done = 1'b0;
      vecs[5].exp_err  = 1'b1;
`else
      vecs[5] = '{b: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h01},
                  len: 6, gaps: 1'b0, exp_done: 1'b1, exp_err: 1'b0, nw: 1,
                  w: {32'h0, 32'h12345678}};
`endif

      for (int k = 0; k < 6; k++) run_vec(k);

      // Zero count: completion timing right after count_hi is accepted.
      apply_reset();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
`ifdef PHOENIX_LOADER_CHECKSUM_EN
      check("zero_wait_checksum", {31'd0, load_done}, 32'd0);
      check("zero_ready_checksum", {31'd0, rx_ready}, 32'd1);
      send_byte(8'h00, 0);
`endif
      check("zero_done_next_cycle", {31'd0, load_done}, 32'd1);
      check("zero_core_release", {31'd0, core_reset}, 32'd0);
      repeat (3) @(negedge CLK);
      check("zero_no_writes", writes_seen, 32'd0);

      // Oversize: rx_ready stays low after the error.
      apply_reset();
      send_byte(8'h01, 0);
      send_byte(8'h04, 0);
      repeat (4) @(negedge CLK);
      check("oversize_ready_low", {31'd0, rx_ready}, 32'd0);
      check("oversize_error", {31'd0, load_error}, 32'd1);

      // Async reset after six payload bytes, then a fresh load.
      apply_reset();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h05, 0);
      send_byte(8'ha0, 0);
      exp_q.push_back('{addr: 12'h000, data: 32'h00a00513});
      send_byte(8'h00, 0);
      send_byte(8'h73, 0);
      send_byte(8'h00, 0);
      @(negedge CLK);
      #2 reset = 1'b1;
      #1;
      check("async_core_reset", {31'd0, core_reset}, 32'd1);
      check("async_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("async_we", {31'd0, mem_write_enable}, 32'd0);
      check("async_writes_before", writes_seen, 32'd1);
      check("async_scoreboard", exp_q.size(), 32'd0);
      @(negedge CLK);
      reset       = 1'b0;
      writes_seen = 0;
      exp_q.delete();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'hef, 0);
      send_byte(8'hbe, 0);
      send_byte(8'had, 0);
      exp_q.push_back('{addr: 12'h000, data: 32'hdeadbeef});
      send_byte(8'hde, 0);
`ifdef PHOENIX_LOADER_CHECKSUM_EN
      send_byte(8'h38, 0);
`endif
      wait_terminal();
      @(negedge CLK);
      check("fresh_done", {31'd0, load_done}, 32'd1);
      check("fresh_writes", writes_seen, 32'd1);
      check("fresh_scoreboard", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/phoenix_program_loader.md
Name: phoenix_program_loader

Overview:
Boot-time program loader for the phoeniX core; the write-side counterpart of the data-memory dump path.
- Accepts a byte stream over a valid/ready interface.
- Assembles little-endian 32-bit words and writes them into byte-addressed instruction memory starting at BASE_ADDRESS.
- Holds the core in reset until the image is fully loaded.
- Sits between the external byte source (UART/host) and the fetch unit's memory write port.

Parameters:
- ADDRESS_WIDTH, 12, byte-address width of instruction memory; capacity = 2**ADDRESS_WIDTH/4 words.
- BASE_ADDRESS, 0, byte address of the first word written; word aligned.

Ports:
- CLK  input  1  core clock
- reset  input  1  asynchronous, active-high reset
- rx_valid  input  1  byte source has a byte
- rx_data  input  8  byte value
- rx_ready  output  1  loader accepts a byte this cycle
- mem_write_enable  output  1  one-cycle word write strobe
- mem_address  output  ADDRESS_WIDTH  byte address of the word being written
- mem_write_data  output  32  word to write
- core_reset  output  1  reset to the phoeniX core; high until the load completes
- load_done  output  1  image loaded successfully
- load_error  output  1  load aborted

Behaviour:
- Interface: one clock (CLK); reset is asynchronous and active-high. Assertion forces all state immediately.
- Reset values: state=INIT, rx_ready=0, mem_write_enable=0, mem_address=BASE_ADDRESS, mem_write_data=0, core_reset=1, load_done=0, load_error=0.
- Byte transfer: occurs on a rising edge when rx_valid && rx_ready. rx_ready is a combinational function of state only; it is high in COUNT_LO, COUNT_HI, DATA and CHECK.
- Stream format: count_lo, count_hi (16-bit word count N), then N words of 4 bytes each, least-significant byte first.
- States:
  - INIT: lasts 1 cycle, then COUNT_LO.
  - COUNT_LO: on a transfer, latch the low count byte -> COUNT_HI.
  - COUNT_HI: on a transfer, form N.
    - N==0 -> CHECK if the checksum feature is enabled, else DONE.
    - N > capacity-BASE_ADDRESS/4 -> ERROR.
    - Otherwise -> DATA.
  - DATA: byte counter 0..3 shifts bytes into the word. The 4th byte transfer -> WRITE.
  - WRITE: exactly 1 cycle.
    - mem_write_enable=1, with mem_address and mem_write_data stable. rx_ready=0.
    - At the edge leaving WRITE, mem_address advances by 4 and the remaining-word count decrements.
    - Remaining > 0 -> DATA; otherwise -> CHECK (feature enabled) or DONE.
  - DONE: terminal. core_reset=0, load_done=1.
  - ERROR: terminal. core_reset=1, load_error=1.
  - DONE and ERROR are left only by reset.
- Latency and throughput:
  - The write strobe occurs in the cycle after the 4th byte's accepting edge.
  - Peak rate is 1 word per 5 cycles.
  - rx_valid gaps stall with no state change.
- mem_address wraps modulo 2**ADDRESS_WIDTH. The capacity check guarantees no wrap in a legal load.
- Reset mid-load: aborts the load. A partially assembled word is discarded. Words already written stay in memory; the loader never clears memory.
- load_done and load_error are never both high.

Optional Feature:
- Macro: PHOENIX_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum modulo 256 covers all payload bytes (the count header is excluded).
  - After the last word (or N==0), state CHECK accepts one further byte.
  - Byte equal to the sum -> DONE; mismatch -> ERROR.
- Undefined:
  - No CHECK state and no sum register.
  - The loader goes to DONE straight after the last WRITE and consumes no trailing byte.

Decomposition:
- Package phoenix_loader_pkg holds:
  - State encoding constants (INIT, COUNT_LO, COUNT_HI, DATA, WRITE, CHECK, DONE, ERROR).
  - BYTES_PER_WORD=4.
  - Count width 16.
- One sub-module, loader_word_assembler:
  - 2-bit byte counter plus 32-bit little-endian shift register.
  - Outputs word_complete and the assembled word; cleared on reset.

Test Plan:
- Basic load, checksum off: stream 02 00 13 05 a0 00 73 00 10 00 with rx_valid held high.
  - Required: write 0x00a00513 @0x000, then write 0x00100073 @0x004, each strobe 1 cycle wide.
  - Required: rx_ready=0 during each WRITE; load_done=1 and core_reset=0 after the 2nd write.
- Checksum on: same stream followed by 3b -> DONE. Same stream followed by 3c -> load_error=1, core_reset stays 1, both writes still occurred.
- Zero count: stream 00 00 -> no mem_write_enable pulses.
  - Checksum off: load_done=1 one cycle after count_hi is accepted.
  - Checksum on: the next byte 00 -> DONE.
- Oversize: stream 01 04 with ADDRESS_WIDTH=12 (N=0x401 > 0x400) -> load_error=1, no writes, rx_ready=0 thereafter.
- Stalls: insert random rx_valid=0 gaps of 0-7 cycles into the basic load -> identical writes and addresses, no byte lost or duplicated.
- Async reset: assert reset after 6 payload bytes, between clock edges.
  - Required immediately: core_reset=1, rx_ready=0, mem_write_enable=0.
  - After release, a fresh 01 00 ef be ad de load writes 0xdeadbeef @BASE_ADDRESS.
